// File: rtl/lcd_shadow_pkg.sv
// Shared types and constants for the HD44780 bus shadow.
// Opcode masks are matched against the leading one of an instruction byte.
package lcd_shadow_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CLEAR
    } state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } bus_wr_t;

    localparam logic [7:0] OP_DDRAM = 8'h80;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_CLEAR = 8'h01;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE1_END  = 7'h27;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE2_END  = 7'h67;

    localparam logic [7:0] BLANK = 8'h20;

    // One-hot of the most significant set bit; zero for a zero byte.
    function automatic logic [7:0] lead_one(input logic [7:0] d);
        lead_one = '0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) lead_one = 8'b1 << i;
        end
    endfunction

endpackage

// File: rtl/lcd_addr_step.sv
// Next address-counter value for one step up or down,
// wrapping between the two DDRAM lines.
module lcd_addr_step
    import lcd_shadow_pkg::*;
(
    input  logic [6:0] addr_i,
    input  logic       inc_i,
    output logic [6:0] addr_o
);

    logic [6:0] base;
    logic [6:0] last;
    logic [6:0] other_base;
    logic [6:0] other_end;

    always_comb begin
        base       = addr_i[6] ? LINE2_BASE : LINE1_BASE;
        last       = addr_i[6] ? LINE2_END  : LINE1_END;
        other_base = addr_i[6] ? LINE1_BASE : LINE2_BASE;
        other_end  = addr_i[6] ? LINE1_END  : LINE2_END;
        addr_o     = addr_i;
        if (inc_i) begin
            // Gap addresses behave as if already past the line end.
            if (addr_i >= last) addr_o = other_base;
            else                addr_o = addr_i + 7'd1;
        end else begin
            if (addr_i == base)     addr_o = other_end;
            else if (addr_i > last) addr_o = last;
            else                    addr_o = addr_i - 7'd1;
        end
    end

endmodule

// File: rtl/lcd_bus_shadow.sv
// Receiver side of the character-LCD bus: decodes writes into
// controller state and mirrors the 2x16 visible DDRAM.
module lcd_bus_shadow
    import lcd_shadow_pkg::*;
#(
    parameter int BUSY_LONG_CYC  = 1520,
    parameter int BUSY_SHORT_CYC = 37
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] cursor_addr,
    output logic       entry_inc,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       func_8bit,
    output logic       func_2line,
    output logic       init_done,
    output logic       cmd_strobe,
    output logic       data_strobe,
    output logic       err_timing,
    output logic       err_rw,
    output logic       err_overrun
);

    localparam int BW = $clog2(BUSY_LONG_CYC + 1);

    state_e     state_q, state_d;
    bus_wr_t    cmd_q, cmd_d;
    bus_wr_t    hold_q, hold_d;
    logic       hold_v_q, hold_v_d;
    logic       e_q;
    logic [BW-1:0] busy_q, busy_d;
    logic [4:0] clr_idx_q, clr_idx_d;
    logic [6:0] cursor_q, cursor_d;
    logic       entry_inc_q, entry_inc_d;
    logic       disp_q, disp_d;
    logic       cur_q, cur_d;
    logic       blink_q, blink_d;
    logic       f8_q, f8_d;
    logic       f2_q, f2_d;
    logic       fs_ok_q, fs_ok_d;
    logic       init_q, init_d;
    logic       cgram_q, cgram_d;
    logic       cmd_stb_q, cmd_stb_d;
    logic       data_stb_q, data_stb_d;
    logic       err_t_q, err_t_d;
    logic       err_rw_q, err_rw_d;
    logic       err_ov_q, err_ov_d;
    logic [7:0] rd_char_q;
    logic [7:0] mem_q [32];

    logic       fall;
    logic       cap;
    bus_wr_t    cap_wr;
    logic [7:0] op;
    logic       step_inc;
    logic [6:0] step_addr;
    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_val;

    assign fall     = e_q & ~LCD_E;
    assign cap      = fall & ~LCD_RW;
    assign cap_wr   = '{rs: LCD_RS, data: LCD_DATA};
    assign op       = lead_one(cmd_q.data);
    assign step_inc = cmd_q.rs ? entry_inc_q : cmd_q.data[2];

    lcd_addr_step u_step (
        .addr_i (cursor_q),
        .inc_i  (step_inc),
        .addr_o (step_addr)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        hold_d      = hold_q;
        hold_v_d    = hold_v_q;
        busy_d      = (busy_q != '0) ? busy_q - BW'(1) : '0;
        clr_idx_d   = clr_idx_q;
        cursor_d    = cursor_q;
        entry_inc_d = entry_inc_q;
        disp_d      = disp_q;
        cur_d       = cur_q;
        blink_d     = blink_q;
        f8_d        = f8_q;
        f2_d        = f2_q;
        fs_ok_d     = fs_ok_q;
        init_d      = init_q;
        cgram_d     = cgram_q;
        cmd_stb_d   = 1'b0;
        data_stb_d  = 1'b0;
        err_t_d     = err_t_q;
        err_rw_d    = err_rw_q;
        err_ov_d    = err_ov_q;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_val      = BLANK;

        if (fall && LCD_RW)      err_rw_d = 1'b1;
        if (cap && busy_q != '0) err_t_d  = 1'b1;

        if (cap && state_q != S_IDLE) begin
            if (hold_v_q) begin
                err_ov_d = 1'b1;
            end else begin
                hold_d   = cap_wr;
                hold_v_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                // The held write goes first; a new capture refills the slot.
                if (hold_v_q) begin
                    cmd_d   = hold_q;
                    state_d = S_APPLY;
                    if (cap) hold_d   = cap_wr;
                    else     hold_v_d = 1'b0;
                end else if (cap) begin
                    cmd_d   = cap_wr;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                state_d = S_IDLE;
                busy_d  = BW'(BUSY_SHORT_CYC);
                if (!cmd_q.rs) begin
                    cmd_stb_d = 1'b1;
                    unique case (op)
                        OP_DDRAM: begin
                            cursor_d = cmd_q.data[6:0];
                            cgram_d  = 1'b0;
                        end
                        OP_CGRAM: cgram_d = 1'b1;
                        OP_FUNC: begin
                            f8_d    = cmd_q.data[4];
                            f2_d    = cmd_q.data[3];
                            fs_ok_d = cmd_q.data[4] & cmd_q.data[3];
                        end
                        OP_SHIFT: begin
                            if (!cmd_q.data[3]) cursor_d = step_addr;
                        end
                        OP_DISP: begin
                            disp_d  = cmd_q.data[2];
                            cur_d   = cmd_q.data[1];
                            blink_d = cmd_q.data[0];
                            if (cmd_q.data[2] && fs_ok_q) init_d = 1'b1;
                        end
                        OP_ENTRY: entry_inc_d = cmd_q.data[1];
                        OP_HOME: begin
                            cursor_d = '0;
                            busy_d   = BW'(BUSY_LONG_CYC);
                        end
                        OP_CLEAR: begin
                            state_d   = S_CLEAR;
                            clr_idx_d = '0;
                            busy_d    = BW'(BUSY_LONG_CYC);
                        end
                        default: ;
                    endcase
                end else begin
                    data_stb_d = 1'b1;
                    if (!cgram_q) begin
                        wr_val   = cmd_q.data;
                        wr_idx   = {cursor_q[6], cursor_q[3:0]};
                        wr_en    = (cursor_q[5:4] == 2'b00);
                        cursor_d = step_addr;
                    end
                end
            end
            S_CLEAR: begin
                wr_en     = 1'b1;
                wr_idx    = clr_idx_q;
                clr_idx_d = clr_idx_q + 5'd1;
                if (clr_idx_q == 5'd31) begin
                    state_d     = S_IDLE;
                    cursor_d    = '0;
                    entry_inc_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            hold_q      <= '0;
            hold_v_q    <= 1'b0;
            e_q         <= 1'b0;
            busy_q      <= '0;
            clr_idx_q   <= '0;
            cursor_q    <= '0;
            entry_inc_q <= 1'b1;
            disp_q      <= 1'b0;
            cur_q       <= 1'b0;
            blink_q     <= 1'b0;
            f8_q        <= 1'b0;
            f2_q        <= 1'b0;
            fs_ok_q     <= 1'b0;
            init_q      <= 1'b0;
            cgram_q     <= 1'b0;
            cmd_stb_q   <= 1'b0;
            data_stb_q  <= 1'b0;
            err_t_q     <= 1'b0;
            err_rw_q    <= 1'b0;
            err_ov_q    <= 1'b0;
            rd_char_q   <= BLANK;
            for (int i = 0; i < 32; i++) mem_q[i] <= BLANK;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            hold_q      <= hold_d;
            hold_v_q    <= hold_v_d;
            e_q         <= LCD_E;
            busy_q      <= busy_d;
            clr_idx_q   <= clr_idx_d;
            cursor_q    <= cursor_d;
            entry_inc_q <= entry_inc_d;
            disp_q      <= disp_d;
            cur_q       <= cur_d;
            blink_q     <= blink_d;
            f8_q        <= f8_d;
            f2_q        <= f2_d;
            fs_ok_q     <= fs_ok_d;
            init_q      <= init_d;
            cgram_q     <= cgram_d;
            cmd_stb_q   <= cmd_stb_d;
            data_stb_q  <= data_stb_d;
            err_t_q     <= err_t_d;
            err_rw_q    <= err_rw_d;
            err_ov_q    <= err_ov_d;
            rd_char_q   <= mem_q[rd_addr];
            if (wr_en) mem_q[wr_idx] <= wr_val;
        end
    end

    assign rd_char     = rd_char_q;
    assign cursor_addr = cursor_q;
    assign entry_inc   = entry_inc_q;
    assign disp_on     = disp_q;
    assign cursor_on   = cur_q;
    assign blink_on    = blink_q;
    assign func_8bit   = f8_q;
    assign func_2line  = f2_q;
    assign init_done   = init_q;
    assign cmd_strobe  = cmd_stb_q;
    assign data_strobe = data_stb_q;
    assign err_timing  = err_t_q;
    assign err_rw      = err_rw_q;
    assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_lcd_bus_shadow.sv
// Directed bench for lcd_bus_shadow: drives bus cycles and
// checks decoded state and the DDRAM shadow against hand values.
module tb_lcd_bus_shadow;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       e = 1'b0;
    logic       rs = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] data = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic [6:0] cursor_addr;
    logic       entry_inc, disp_on, cursor_on, blink_on;
    logic       func_8bit, func_2line, init_done;
    logic       cmd_strobe, data_strobe;
    logic       err_timing, err_rw, err_overrun;

    int total = 0;
    int bad = 0;
    int n_cmd = 0;
    int n_data = 0;
    logic [7:0] v;

    lcd_bus_shadow dut (
        .clk         (clk),
        .rst         (rst),
        .LCD_E       (e),
        .LCD_RS      (rs),
        .LCD_RW      (rw),
        .LCD_DATA    (data),
        .rd_addr     (rd_addr),
        .rd_char     (rd_char),
        .cursor_addr (cursor_addr),
        .entry_inc   (entry_inc),
        .disp_on     (disp_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .func_8bit   (func_8bit),
        .func_2line  (func_2line),
        .init_done   (init_done),
        .cmd_strobe  (cmd_strobe),
        .data_strobe (data_strobe),
        .err_timing  (err_timing),
        .err_rw      (err_rw),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_strobe)  n_cmd++;
        if (data_strobe) n_data++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic r_s, input logic r_w,
                       input logic [7:0] d, input int gap);
        @(negedge clk);
        rs = r_s; rw = r_w; data = d; e = 1'b1;
        @(negedge clk);
        e = 1'b0;
        @(negedge clk);
        rw = 1'b0;
        cyc(gap);
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] q);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        q = rd_char;
    endtask

    initial begin
        cyc(3);
        check("rst_cursor", 32'(cursor_addr), 32'h00);
        check("rst_entry", 32'(entry_inc), 32'h1);
        check("rst_rdchar", 32'(rd_char), 32'h20);
        check("rst_errs", 32'({err_timing, err_rw, err_overrun}), 32'h0);
        check("rst_flags", 32'({disp_on, cursor_on, blink_on, func_8bit,
                                func_2line, init_done}), 32'h0);
        rst = 1'b1;
        cyc(2);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), v);
            check($sformatf("blank_%0d", i), 32'(v), 32'h20);
        end

        bus(1'b0, 1'b0, 8'h38, 45);
        check("fs_8bit", 32'(func_8bit), 32'h1);
        check("fs_2line", 32'(func_2line), 32'h1);
        check("init_early", 32'(init_done), 32'h0);
        bus(1'b0, 1'b0, 8'h0C, 45);
        check("disp_on", 32'(disp_on), 32'h1);
        check("cur_blink", 32'({cursor_on, blink_on}), 32'h0);
        check("init_done", 32'(init_done), 32'h1);
        check("no_timing", 32'(err_timing), 32'h0);

        bus(1'b0, 1'b0, 8'h80, 45);
        bus(1'b1, 1'b0, 8'h48, 45);
        bus(1'b1, 1'b0, 8'h49, 45);
        rd(5'd0, v);
        check("hi_0", 32'(v), 32'h48);
        rd(5'd1, v);
        check("hi_1", 32'(v), 32'h49);
        check("hi_cursor", 32'(cursor_addr), 32'h02);

        bus(1'b0, 1'b0, 8'hA7, 45);
        check("set_27", 32'(cursor_addr), 32'h27);
        bus(1'b1, 1'b0, 8'h41, 45);
        check("wrap_40", 32'(cursor_addr), 32'h40);
        bus(1'b1, 1'b0, 8'h42, 45);
        check("line2_cursor", 32'(cursor_addr), 32'h41);
        rd(5'd16, v);
        check("line2_16", 32'(v), 32'h42);
        rd(5'd15, v);
        check("gap_nostore", 32'(v), 32'h20);
        bus(1'b0, 1'b0, 8'h04, 45);
        check("entry_dec", 32'(entry_inc), 32'h0);
        bus(1'b0, 1'b0, 8'h80, 45);
        bus(1'b1, 1'b0, 8'h43, 45);
        check("dec_wrap_67", 32'(cursor_addr), 32'h67);
        rd(5'd0, v);
        check("dec_store_0", 32'(v), 32'h43);
        bus(1'b0, 1'b0, 8'h14, 45);
        check("shift_right", 32'(cursor_addr), 32'h00);
        bus(1'b0, 1'b0, 8'h10, 45);
        check("shift_left", 32'(cursor_addr), 32'h67);
        check("n_cmd", 32'(n_cmd), 32'd8);
        check("n_data", 32'(n_data), 32'd5);

        bus(1'b0, 1'b0, 8'h40, 45);
        bus(1'b1, 1'b0, 8'h55, 45);
        check("cgram_cursor", 32'(cursor_addr), 32'h67);
        rd(5'd0, v);
        check("cgram_nostore", 32'(v), 32'h43);
        bus(1'b0, 1'b0, 8'h81, 45);
        check("exit_cgram", 32'(cursor_addr), 32'h01);
        bus(1'b0, 1'b0, 8'h06, 45);
        check("entry_inc", 32'(entry_inc), 32'h1);
        check("pre_clr_errs", 32'({err_timing, err_rw, err_overrun}), 32'h0);

        bus(1'b0, 1'b0, 8'h01, 10);
        bus(1'b1, 1'b0, 8'h58, 10);
        bus(1'b1, 1'b0, 8'h59, 10);
        cyc(60);
        rd(5'd0, v);
        check("held_byte", 32'(v), 32'h58);
        rd(5'd1, v);
        check("clr_1", 32'(v), 32'h20);
        rd(5'd16, v);
        check("clr_16", 32'(v), 32'h20);
        rd(5'd31, v);
        check("clr_31", 32'(v), 32'h20);
        check("clr_cursor", 32'(cursor_addr), 32'h01);
        check("clr_timing", 32'(err_timing), 32'h1);
        check("clr_overrun", 32'(err_overrun), 32'h1);
        check("clr_no_rw", 32'(err_rw), 32'h0);

        bus(1'b0, 1'b1, 8'h80, 5);
        check("rw_cursor", 32'(cursor_addr), 32'h01);
        check("rw_flag", 32'(err_rw), 32'h1);

        bus(1'b0, 1'b0, 8'h01, 8);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_cursor", 32'(cursor_addr), 32'h00);
        check("mid_entry", 32'(entry_inc), 32'h1);
        check("mid_errs", 32'({err_timing, err_rw, err_overrun}), 32'h0);
        check("mid_flags", 32'({disp_on, cursor_on, blink_on, func_8bit,
                                func_2line, init_done}), 32'h0);
        check("mid_rdchar", 32'(rd_char), 32'h20);
        cyc(3);
        rst = 1'b1;
        cyc(50);
        rd(5'd0, v);
        check("mid_mem0", 32'(v), 32'h20);
        check("mid_cursor2", 32'(cursor_addr), 32'h00);
        check("mid_errs2", 32'({err_timing, err_rw, err_overrun}), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_shadow.md
Name: lcd_bus_shadow

Overview:
- Receiving end of the HD44780-style character-LCD bus (LCD_E/RS/RW/DATA) driven by the text-LCD writer.
- Decodes every write into the controller's internal state: address counter, entry mode, display control, function set.
- Keeps a 2x16 DDRAM shadow, readable by a debug/readback path and the verification bench.
- Flags protocol violations: writes during emulated busy time, read cycles, and overruns.

Parameters:
- BUSY_LONG_CYC, 1520: busy window, in clk cycles, after clear or return-home (1.52 ms at 1 MHz).
- BUSY_SHORT_CYC, 37: busy window, in clk cycles, after any other instruction or data write.

Ports:
- clk  in  1  system clock; the LCD bus is driven from this same clock domain.
- rst  in  1  asynchronous, active-low reset.
- LCD_E  in  1  enable; data is latched on its falling edge.
- LCD_RS  in  1  0 = instruction, 1 = data.
- LCD_RW  in  1  0 = write, 1 = read.
- LCD_DATA  in  8  bus byte.
- rd_addr  in  5  shadow index: 0-15 = line 1, 16-31 = line 2.
- rd_char  out  8  shadow byte at rd_addr, registered, 1-cycle latency.
- cursor_addr  out  7  HD44780 address counter.
- entry_inc  out  1  I/D bit.
- disp_on, cursor_on, blink_on  out  1 each  D, C, B bits.
- func_8bit, func_2line  out  1 each  DL, N bits.
- init_done  out  1  high once function set with DL=1, N=1 has been applied, followed later by display control with D=1.
- cmd_strobe  out  1  1-cycle pulse when an instruction is applied.
- data_strobe  out  1  1-cycle pulse when a data byte is applied.
- err_timing, err_rw, err_overrun  out  1 each  sticky error flags; cleared only by rst.

Behaviour:
- Reset values:
  - Every shadow byte = 0x20; cursor_addr = 0; entry_inc = 1.
  - disp_on, cursor_on, blink_on, func_8bit, func_2line, init_done = 0.
  - All strobes and error flags = 0; rd_char = 0x20; FSM in IDLE; busy counter = 0.
- Capture:
  - LCD_E is registered once; falling edge = E_q=1 and E=0. RS/RW/DATA are sampled in the same cycle as the edge is detected.
  - If RW=1, the cycle is ignored and err_rw is set.
- Hold register (1 entry):
  - The captured write enters hold when the FSM is not IDLE; in IDLE it is applied in the next cycle.
  - A capture while hold is full is dropped and sets err_overrun.
- Busy check: a capture while the busy counter is nonzero sets err_timing. The write is still applied.
- Instruction decode (RS=0, by leading one):
  - 0x01 clear: enter CLEAR, sweep 0x20 into indices 0..31 at one per cycle (32 cycles), then cursor_addr = 0, entry_inc = 1; busy = BUSY_LONG_CYC.
  - 0x02/0x03 home: cursor_addr = 0; busy = BUSY_LONG_CYC.
  - 0x04-0x07 entry mode: entry_inc = bit1; the S bit is ignored.
  - 0x08-0x0F display control: D = bit2, C = bit1, B = bit0.
  - 0x10-0x1F: if S/C (bit3) = 0, the cursor moves by +1 when R/L (bit2) = 1, otherwise -1. Display shift is ignored.
  - 0x20-0x3F function set: DL = bit4, N = bit3.
  - 0x40-0x7F: enter CGRAM mode. Subsequent data writes are discarded and the address counter is unchanged.
  - 0x80-0xFF: cursor_addr = DATA[6:0]; CGRAM mode is exited.
  - Every instruction except clear and home loads busy = BUSY_SHORT_CYC.
- Data write (RS=1), outside CGRAM mode:
  - If cursor_addr is 0x00-0x0F, the byte is stored at index cursor_addr.
  - If cursor_addr is 0x40-0x4F, the byte is stored at index 16 + (cursor_addr - 0x40).
  - Any other address: the byte is not stored.
  - The counter then steps per entry_inc; busy = BUSY_SHORT_CYC.
- Address counter wrap:
  - Increment: 0x27 → 0x40 and 0x67 → 0x00.
  - Decrement: 0x00 → 0x67 and 0x40 → 0x27.
  - A set-address value in the gaps (0x28-0x3F, 0x68-0x7F) is kept as given; the next step wraps per the line it belongs to.
- FSM states:
  - IDLE → APPLY on a capture or when hold is valid.
  - APPLY → CLEAR for clear; otherwise APPLY → IDLE after 1 cycle.
  - CLEAR → IDLE after index 31 is written. The hold register drains on return to IDLE.
- Busy counter: decrements to 0 every cycle, independent of the FSM.
- Read port: a read of an index written in the same cycle returns the old value.
- Reset mid-operation (including mid-CLEAR) returns everything to reset values immediately.

Decomposition:
- Package lcd_shadow_pkg holds:
  - FSM state enum.
  - Instruction opcode masks.
  - Line base addresses 0x00/0x40 and line end 0x27/0x67.
  - Blank character 0x20.
- Sub-module lcd_addr_step: combinational next-address calculation with wrap, reused for data writes and cursor shift.

Test Plan:
- Reset, then read all 32 indices → each returns 0x20; cursor_addr = 0, entry_inc = 1.
- Write 0x38, then 0x0C, each ≥ 37 cycles apart → func_8bit = 1, func_2line = 1, disp_on = 1, init_done = 1, err_timing = 0.
- Write 0x80, then data "HI" → shadow[0] = 0x48, shadow[1] = 0x49, cursor_addr = 0x02.
- Write 0xA7 (addr 0x27), then data 0x41, 0x42 → cursor_addr ends at 0x41, shadow[16] = 0x42. Then write 0x04 (decrement) and data 0x43 at 0x00 → cursor_addr = 0x67.
- Write 0x01, with the next write 10 cycles later → 32-cycle clear completes, err_timing = 1, the held byte is applied after CLEAR. A third capture while hold is full → err_overrun = 1.
- Pulse E with RW=1 → no state change, err_rw = 1. Assert rst mid-CLEAR → all outputs return to reset values.
